// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encodings
// and the default end-of-program marker.
package inst_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Word assembler: packs four bytes MSB-first into a 32-bit word. word/word_valid
// are combinational so the loader can register the write on the 4th-byte edge.
module inst_mem_loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      byte_cnt <= 2'd0;
      shift_q  <= 24'd0;
    end else if (byte_valid) begin
      shift_q  <= {shift_q[15:0], byte_data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // The 4th byte completes the word straight from the input bus.
  assign word       = {shift_q, byte_data};
  assign word_valid = byte_valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: byte stream -> sequential 32-bit writes until HALT.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and checksum_err.
//
// Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte is
// consumed on every clk edge where rx_valid=1 and the loader is in LOAD.
// write_inst_mem is a one-cycle strobe; addr/data are stable while it is high.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int          ADDR_BITS = 8,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 write_inst_mem,
  output logic [ADDR_BITS-1:0] inst_mem_addr,
  output logic [31:0]          inst_mem_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [ADDR_BITS:0]   words_loaded,
`ifdef LOADER_CHECKSUM_EN
  output logic                 checksum_err,
`endif
  output logic [1:0]           state_dbg
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  state_t               state, next_state;
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [31:0]          word;
  logic                 word_valid;
  logic                 byte_accept;
  logic                 load_start;
  logic                 halt_wr;
  logic                 last_wr;

  assign byte_accept = rx_valid && (state == ST_LOAD);
  assign load_start  = start && ((state == ST_IDLE) || (state == ST_DONE));
  // End conditions are taken from the registered strobe so done follows it by one cycle.
  assign halt_wr     = write_inst_mem && (inst_mem_data == HALT_WORD);
  assign last_wr     = write_inst_mem && (inst_mem_addr == LAST_ADDR);

  inst_mem_loader_word_assembler u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_start),
    .byte_valid (byte_accept),
    .byte_data  (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_LOAD;
      ST_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
        if (halt_wr)      next_state = ST_CHECK;
`else
        if (halt_wr)      next_state = ST_DONE;
`endif
        else if (last_wr) next_state = ST_DONE;
      end
      ST_CHECK: if (rx_valid) next_state = ST_DONE;
      ST_DONE:  if (start) next_state = ST_LOAD;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_LOAD) || (state == ST_CHECK);
    done      = (state == ST_DONE);
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      write_inst_mem <= 1'b0;
      inst_mem_addr  <= '0;
      inst_mem_data  <= 32'd0;
      wr_ptr         <= '0;
      words_loaded   <= '0;
      overflow       <= 1'b0;
    end else begin
      write_inst_mem <= word_valid;
      if (load_start) begin
        wr_ptr       <= '0;
        words_loaded <= '0;
        overflow     <= 1'b0;
      end
      if (word_valid) begin
        inst_mem_addr <= wr_ptr;
        inst_mem_data <= word;
        wr_ptr        <= wr_ptr + 1'b1;
        words_loaded  <= words_loaded + 1'b1;
      end
      if ((state == ST_LOAD) && last_wr && !halt_wr) overflow <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk_xor;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chk_xor      <= 8'd0;
      checksum_err <= 1'b0;
    end else if (load_start) begin
      chk_xor      <= 8'd0;
      checksum_err <= 1'b0;
    end else if (byte_accept) begin
      chk_xor <= chk_xor ^ rx_data;
    end else if ((state == ST_CHECK) && rx_valid) begin
      checksum_err <= (rx_data != chk_xor);
    end
  end
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: an 8-bit-address instance for the
// main flows and a 2-bit-address instance for the memory-full case.
module tb_inst_mem_loader;
  import inst_mem_loader_pkg::*;

  localparam int W = 40;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, start_s = 1'b0;
  logic       rx_valid = 1'b0, rx_valid_s = 1'b0;
  logic [7:0] rx_data = 8'd0;

  logic        wr, busy, done, ovf;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [8:0]  wl;
  logic [1:0]  st;
  logic        wr_s, busy_s, done_s, ovf_s;
  logic [1:0]  addr_s;
  logic [31:0] data_s;
  logic [2:0]  wl_s;
  logic [1:0]  st_s;
`ifdef LOADER_CHECKSUM_EN
  logic        chk_err, chk_err_s;
`endif

  inst_mem_loader #(.ADDR_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .write_inst_mem(wr), .inst_mem_addr(addr), .inst_mem_data(data),
    .busy(busy), .done(done), .overflow(ovf), .words_loaded(wl),
`ifdef LOADER_CHECKSUM_EN
    .checksum_err(chk_err),
`endif
    .state_dbg(st)
  );

  inst_mem_loader #(.ADDR_BITS(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .rx_data(rx_data), .rx_valid(rx_valid_s),
    .write_inst_mem(wr_s), .inst_mem_addr(addr_s), .inst_mem_data(data_s),
    .busy(busy_s), .done(done_s), .overflow(ovf_s), .words_loaded(wl_s),
`ifdef LOADER_CHECKSUM_EN
    .checksum_err(chk_err_s),
`endif
    .state_dbg(st_s)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_s_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           exp_addr = 0;
  logic [7:0]   exp_xor  = 8'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks (inputs change 1 time unit after the active edge)
  task automatic idle(input int n);
    rx_valid   = 1'b0;
    rx_valid_s = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    rx_data = b;
    if (sel) rx_valid_s = 1'b1;
    else     rx_valid   = 1'b1;
    @(posedge clk);
    #1;
    exp_xor ^= b;
  endtask

  task automatic pulse_start(input bit sel, input bit arm);
    if (sel) start_s = 1'b1;
    else     start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    start_s = 1'b0;
    if (arm) begin
      exp_addr = 0;
      exp_xor  = 8'd0;
    end
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w, input int gap, input bit expect_wr);
    logic [7:0] a8;
    a8 = exp_addr[7:0];
    if (expect_wr) begin
      if (sel) exp_s_q.push_back({a8, w});
      else     exp_q.push_back({a8, w});
    end
    for (int i = 0; i < 4; i++) send_byte(sel, w[31-8*i -: 8]);
    if (expect_wr) begin
      check("wr_latency", sel ? wr_s : wr, 1);
      exp_addr++;
    end else begin
      check("no_wr", sel ? wr_s : wr, 0);
    end
    if (gap > 0) idle(gap);
  endtask

  task automatic finish_load(input bit sel);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = exp_xor;
    send_byte(sel, c);
    idle(1);
`else
    if (sel) idle(0);
`endif
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    while (((sel ? done_s : done) !== 1'b1) && (n < 40)) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_wait", sel ? done_s : done, 1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if (w == 32'hFFFF_FFFF) w = 32'h0;
    return w;
  endfunction

  // write monitor: every strobe pops one expected {addr, data}
  logic prev_wr = 1'b0, prev_wr_s = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst === 1'b1) begin
      if (wr === 1'b1) begin
        check("strobe_len", prev_wr, 0);
        if (exp_q.size() == 0) check("wr_queue", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("wr_addr_data", {addr, data}, e);
        end
      end
      if (wr_s === 1'b1) begin
        check("strobe_len_s", prev_wr_s, 0);
        if (exp_s_q.size() == 0) check("wr_queue_s", exp_s_q.size(), 1);
        else begin
          e = exp_s_q.pop_front();
          check("wr_addr_data_s", {6'd0, addr_s, data_s}, e);
        end
      end
    end
    prev_wr   = wr;
    prev_wr_s = wr_s;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr", wr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_wl", wl, 0);
    check("rst_state", st, ST_IDLE);
    rst = 1'b1;
    idle(2);

    // bytes before start are ignored
    send_word(0, 32'hA1B2_C3D4, 1, 0);
    check("idle_state", st, ST_IDLE);

    // basic load: one word + HALT
    pulse_start(0, 1);
    send_word(0, 32'h1234_5678, 1, 1);
    send_word(0, 32'hFFFF_FFFF, 1, 1);
    finish_load(0);
    wait_done(0);
    check("t1_wl", wl, 2);
    check("t1_busy", busy, 0);
    check("t1_ovf", ovf, 0);

    // start while busy is ignored
    pulse_start(0, 1);
    exp_q.push_back({8'd0, 32'hCAFE_BABE});
    send_byte(0, 8'hCA);
    send_byte(0, 8'hFE);
    start = 1'b1;
    send_byte(0, 8'hBA);
    start = 1'b0;
    check("start_ignored", st, ST_LOAD);
    send_byte(0, 8'hBE);
    exp_addr = 1;
    idle(1);
    send_word(0, 32'hFFFF_FFFF, 1, 1);
    finish_load(0);
    wait_done(0);
    check("t5_wl", wl, 2);

    // bytes in DONE are ignored
    send_word(0, 32'h1122_3344, 1, 0);
    check("done_state", st, ST_DONE);

    // start in DONE clears flags; back-to-back bytes
    pulse_start(0, 1);
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    check("restart_wl", wl, 0);
    for (int i = 0; i < 3; i++) send_word(0, rand_word(), 0, 1);
    send_word(0, 32'hFFFF_FFFF, 1, 1);
    finish_load(0);
    wait_done(0);
    check("t2_wl", wl, 4);

    // reset in the middle of a word
    pulse_start(0, 1);
    send_byte(0, 8'h55);
    send_byte(0, 8'h66);
    rx_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_wr", wr, 0);
    check("abort_busy", busy, 0);
    check("abort_data", data, 0);
    check("abort_wl", wl, 0);
    check("abort_state", st, ST_IDLE);
    rst = 1'b1;
    idle(1);
    pulse_start(0, 1);
    send_word(0, 32'hDEAD_BEEF, 1, 1);
    send_word(0, 32'hFFFF_FFFF, 1, 1);
    finish_load(0);
    wait_done(0);
    check("t4_wl", wl, 2);

    // small memory: fill without HALT
    pulse_start(1, 1);
    for (int i = 0; i < 4; i++) send_word(1, rand_word(), 1, 1);
    wait_done(1);
    check("ovf_flag", ovf_s, 1);
    check("ovf_wl", wl_s, 4);
    check("ovf_busy", busy_s, 0);
    send_word(1, rand_word(), 1, 0);

    // small memory: HALT at the last address is not an overflow
    pulse_start(1, 1);
    check("ovf_cleared", ovf_s, 0);
    for (int i = 0; i < 3; i++) send_word(1, rand_word(), 1, 1);
    send_word(1, 32'hFFFF_FFFF, 1, 1);
    finish_load(1);
    wait_done(1);
    check("halt_last_ovf", ovf_s, 0);
    check("halt_last_wl", wl_s, 4);

`ifdef LOADER_CHECKSUM_EN
    pulse_start(0, 1);
    send_word(0, 32'h0102_0304, 1, 1);
    send_word(0, 32'hFFFF_FFFF, 1, 1);
    check("chk_state", st, ST_CHECK);
    send_byte(0, 8'h04);
    idle(1);
    wait_done(0);
    check("chk_ok", chk_err, 0);
    pulse_start(0, 1);
    send_word(0, 32'h0102_0304, 1, 1);
    send_word(0, 32'hFFFF_FFFF, 1, 1);
    send_byte(0, 8'h05);
    idle(1);
    wait_done(0);
    check("chk_bad", chk_err, 1);
`endif

    idle(3);
    check("q_empty", exp_q.size(), 0);
    check("q_s_empty", exp_s_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
